// File: rtl/fetch_unit.sv
// Nibble-serial instruction fetch: four 4-bit RAM reads are assembled into
// one 16-bit instruction, held under a valid/ready handshake, with jump redirect.
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_in,
  input  logic [3:0]  mem_out,
  input  logic        jump,
  input  logic [11:0] jump_addr,
  output logic [15:0] instr,
  output logic [11:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

  state_t      state;
  state_t      next_state;
  logic [11:0] pc;
  logic [1:0]  cnt;
  logic [15:0] shreg;
  logic        rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (cnt == 2'd3) next_state = DRAIN;
      DRAIN:   next_state = HOLD;
      HOLD:    if (instr_ready) next_state = FETCH;
      default: next_state = FETCH;
    endcase
    if (jump) next_state = FETCH;
  end

  // Gating with rst_n keeps the strobe low while reset is asserted.
  always_comb begin
    mem_read  = rst_n && (state == FETCH);
    mem_addr  = pc;
    mem_write = 1'b0;
    mem_in    = 4'h0;
  end

  // rd_q marks that mem_out carries data for a read issued last cycle; clearing
  // it on jump drops the in-flight nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      cnt         <= 2'd0;
      shreg       <= 16'h0;
      rd_q        <= 1'b0;
      instr_pc    <= 12'h0;
      instr_valid <= 1'b0;
    end else if (jump) begin
      pc          <= jump_addr;
      cnt         <= 2'd0;
      shreg       <= 16'h0;
      rd_q        <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      rd_q <= mem_read;
      if (rd_q) shreg <= {shreg[11:0], mem_out};
      case (state)
        FETCH: begin
          pc  <= pc + 12'd1;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd0) instr_pc <= pc;
        end
        DRAIN: instr_valid <= 1'b1;
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            cnt         <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr = shreg;

endmodule
